// File: rtl/fpmul_pkg.sv
// ============================================================================
// fpmul_pkg
// ----------------------------------------------------------------------------
// Shared types and helpers for the fpmul_sched block.
// Word format: [15:11] unsigned exponent, [10:0] fraction, no sign field.
// Optional feature macro used by the block: FPMUL_SCHED_FASTNORM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpmul_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 11;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } fpmul_state_t;

    function automatic logic [EXP_W-1:0] word_exp(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:FRAC_W];
    endfunction

    function automatic logic [FRAC_W-1:0] word_frac(input logic [WORD_W-1:0] w);
        return w[FRAC_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] make_word(input logic [EXP_W-1:0]  e,
                                                    input logic [FRAC_W-1:0] f);
        return {e, f};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpmul_norm.sv
// ============================================================================
// fpmul_norm
// ----------------------------------------------------------------------------
// Fraction multiply and post-normalisation datapath for fpmul_sched.
// Holds the working exponent/product registers.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture exp = ea+eb and the upper product half from op_a/op_b
//   step       : normalisation cycle (one-bit shift in the default build)
//   op_a, op_b : captured operand words
//   norm_done  : result is normalised (or zero) and ready to be taken
//   result     : normalised result word (valid while norm_done)
// Macro FPMUL_SCHED_FASTNORM_EN: defined -> leading-zero count normalises in
// a single cycle; undefined -> one shift per cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpmul_norm
    import fpmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    output logic              norm_done,
    output logic [WORD_W-1:0] result
);

    logic [EXP_W-1:0]    exp_q;
    logic [FRAC_W-1:0]   prod_q;
    logic [2*FRAC_W-1:0] full_prod;
    logic [FRAC_W-1:0]   prod_hi;
    logic                prod_zero;

    assign full_prod = {{FRAC_W{1'b0}}, word_frac(op_a)} * {{FRAC_W{1'b0}}, word_frac(op_b)};
    // Only the upper half of the product is kept; the low half is truncated.
    assign prod_hi   = FRAC_W'(full_prod >> FRAC_W);
    assign prod_zero = (prod_q == '0);

`ifdef FPMUL_SCHED_FASTNORM_EN
    logic [3:0] shamt;
    logic       unused_step;

    assign unused_step = step;

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        shamt = '0;
        for (int i = 0; i < FRAC_W; i++) begin
            if (prod_q[i]) begin
                shamt = 4'(FRAC_W - 1 - i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q  <= '0;
            prod_q <= '0;
        end else if (load) begin
            exp_q  <= word_exp(op_a) + word_exp(op_b);
            prod_q <= prod_hi;
        end
    end

    assign norm_done = 1'b1;
    assign result    = prod_zero ? '0
                                 : make_word(exp_q - EXP_W'(shamt), prod_q << shamt);
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q  <= '0;
            prod_q <= '0;
        end else if (load) begin
            exp_q  <= word_exp(op_a) + word_exp(op_b);
            prod_q <= prod_hi;
        end else if (step && !norm_done) begin
            // Exponent underflow wraps modulo 32 silently.
            prod_q <= prod_q << 1;
            exp_q  <= exp_q - 1'b1;
        end
    end

    assign norm_done = prod_zero || prod_q[FRAC_W-1];
    assign result    = prod_zero ? '0 : make_word(exp_q, prod_q);
`endif

endmodule

`default_nettype wire

// File: rtl/fpmul_sched.sv
// ============================================================================
// fpmul_sched
// ----------------------------------------------------------------------------
// Round-robin scheduler sharing one unsigned half-width FP multiplier among
// NUM_REQ requesters. One operation in flight: IDLE -> MUL -> NORM -> DONE.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester request
//   req_a, req_b  : packed operands, requester i at [16i+15:16i]
//   req_ready     : one-hot accept strobe (combinational, IDLE only)
//   rsp_valid     : result available (DONE)
//   rsp_id        : requester owning the result
//   rsp_data      : result word
//   rsp_ready     : consumer accepts result
//   busy          : state is not IDLE
// Macro FPMUL_SCHED_FASTNORM_EN selects single-cycle normalisation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpmul_sched
    import fpmul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [WORD_W*NUM_REQ-1:0] req_a,
    input  logic [WORD_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [WORD_W-1:0]         rsp_data,
    input  logic                      rsp_ready,
    output logic                      busy
);

    fpmul_state_t      state, state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   id_q;
    logic              found;
    logic [WORD_W-1:0] op_a, op_b;
    logic [WORD_W-1:0] rsp_data_q;
    logic              norm_done;
    logic [WORD_W-1:0] norm_result;

    // Search upward from ptr with wrap. Iterating from the farthest offset
    // down lets the nearest valid requester overwrite earlier candidates.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    req_ready[grant] = 1'b1;
                    state_next       = S_MUL;
                end
            end
            S_MUL:   state_next = S_NORM;
            S_NORM:  if (norm_done) state_next = S_DONE;
            S_DONE:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            id_q       <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_data_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && found) begin
                id_q <= grant;
                op_a <= req_a[WORD_W*grant +: WORD_W];
                op_b <= req_b[WORD_W*grant +: WORD_W];
            end
            // Result is frozen here so it stays stable through DONE back-pressure.
            if (state == S_NORM && norm_done) begin
                rsp_data_q <= norm_result;
            end
            if (state == S_DONE && rsp_ready) begin
                ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    fpmul_norm u_norm (
        .clk       (clk),
        .rst       (rst),
        .load      (state == S_MUL),
        .step      (state == S_NORM),
        .op_a      (op_a),
        .op_b      (op_b),
        .norm_done (norm_done),
        .result    (norm_result)
    );

    assign rsp_valid = (state == S_DONE);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpmul_sched.sv
// ============================================================================
// tb_fpmul_sched
// ----------------------------------------------------------------------------
// Self-checking bench for fpmul_sched (NUM_REQ = 4). A cycle-level reference
// model tracks grants, results and response latency from plain arithmetic;
// directed tests add literal expectations.
// Macro FPMUL_SCHED_FASTNORM_EN selects the expected latencies.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpmul_sched;

    localparam int N = 4;

`ifdef FPMUL_SCHED_FASTNORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_data;
    logic            rsp_ready;
    logic            busy;

    logic [15:0] a_arr [N];
    logic [15:0] b_arr [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = a_arr[i];
            req_b[16*i +: 16] = b_arr[i];
        end
    end

    fpmul_sched #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: plain integers, normalise by doubling.
    function automatic void model_op(input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] r, output int k);
        int e, fa, fb, p;
        e  = int'(a[15:11]) + int'(b[15:11]);
        fa = int'(a[10:0]);
        fb = int'(b[10:0]);
        p  = (fa * fb) / 2048;
        k  = 0;
        if (p == 0) begin
            r = 16'h0000;
        end else begin
            while (p < 1024) begin
                p = p * 2;
                e = e - 1;
                k++;
            end
            e = ((e % 32) + 32) % 32;
            r = 16'(e * 2048 + p);
        end
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int off = 0; off < N; off++) begin
            if (v[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    // Cycle-level model: 0 idle, 1 working, 2 response pending.
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    int          m_timer = 0;
    int          m_lat   = 0;
    int          m_k     = 0;
    logic [15:0] m_data  = '0;

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ready;
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
        end else begin
            if (m_phase == 1) begin
                m_timer++;
                if (m_timer == m_lat) m_phase = 2;
            end
            case (m_phase)
                0: begin
                    g         = model_grant(req_valid, m_ptr);
                    exp_ready = (g >= 0) ? N'(1 << g) : '0;
                    chk("idle_req_ready", 32'(req_ready), 32'(exp_ready));
                    chk("idle_busy", 32'(busy), 0);
                    chk("idle_rsp_valid", 32'(rsp_valid), 0);
                    if (g >= 0) begin
                        m_id = g;
                        model_op(a_arr[g], b_arr[g], m_data, m_k);
                        m_lat   = FAST ? 3 : 3 + m_k;
                        m_timer = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    chk("work_req_ready", 32'(req_ready), 0);
                    chk("work_busy", 32'(busy), 1);
                    chk("work_rsp_valid", 32'(rsp_valid), 0);
                end
                default: begin
                    chk("done_req_ready", 32'(req_ready), 0);
                    chk("done_busy", 32'(busy), 1);
                    chk("done_rsp_valid", 32'(rsp_valid), 1);
                    chk("done_rsp_id", 32'(rsp_id), 32'(m_id));
                    chk("done_rsp_data", 32'(rsp_data), 32'(m_data));
                    if (rsp_ready) begin
                        m_ptr   = (m_id + 1) % N;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    // Wait (bounded) for req_ready[idx] at a negedge; returns accept cycle.
    task automatic wait_accept(input int idx, output int t);
        bit got = 0;
        t = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                got = 1;
                t   = cyc;
            end
        end
        chk("accept_seen", 32'(got), 1);
    endtask

    task automatic wait_rsp(output int t);
        bit got = 0;
        t = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                t   = cyc;
            end
        end
        chk("rsp_seen", 32'(got), 1);
    endtask

    task automatic run_single(input int idx, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] exp_d, input int exp_lat);
        int t0, tv;
        a_arr[idx] = a;
        b_arr[idx] = b;
        req_valid  = N'(1 << idx);
        wait_accept(idx, t0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(tv);
        chk("single_latency", 32'(tv - t0), 32'(exp_lat));
        chk("single_data", 32'(rsp_data), 32'(exp_d));
        chk("single_id", 32'(rsp_id), 32'(idx));
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [15:0] r, d0;
        int          k, t, id0;

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end

        // Pin the reference arithmetic with hand-computed values.
        model_op(16'h0C00, 16'h1400, r, k);
        chk("model_r0", 32'(r), 32'h1400); chk("model_k0", 32'(k), 1);
        model_op(16'h07FF, 16'h07FF, r, k);
        chk("model_r1", 32'(r), 32'h07FE); chk("model_k1", 32'(k), 0);
        model_op(16'h0800, 16'h0FFF, r, k);
        chk("model_r2", 32'(r), 32'h0000); chk("model_k2", 32'(k), 0);
        model_op(16'h0020, 16'h0040, r, k);
        chk("model_r3", 32'(r), 32'hB400); chk("model_k3", 32'(k), 10);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_data", 32'(rsp_data), 0);
        chk("reset_busy", 32'(busy), 0);
        @(posedge clk); #1;

        // Directed single operations.
        run_single(0, 16'h0C00, 16'h1400, 16'h1400, FAST ? 3 : 4);
        run_single(1, 16'h07FF, 16'h07FF, 16'h07FE, 3);
        run_single(2, 16'h0800, 16'h0FFF, 16'h0000, 3);
        run_single(3, 16'h0020, 16'h0040, 16'hB400, FAST ? 3 : 13);

        // Round robin with all requesters valid; pointer is back at 0.
        a_arr[0] = 16'h0C00; b_arr[0] = 16'h1400;
        a_arr[1] = 16'h07FF; b_arr[1] = 16'h07FF;
        a_arr[2] = 16'h3A5C; b_arr[2] = 16'h1234;
        a_arr[3] = 16'h0020; b_arr[3] = 16'h0040;
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            wait_rsp(t);
            chk("rr_grant", 32'(rsp_id), 32'(i % N));
            @(posedge clk); #1;
        end

        // Back-pressure in DONE.
        rsp_ready = 1'b0;
        wait_rsp(t);
        d0  = rsp_data;
        id0 = int'(rsp_id);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(d0));
            chk("hold_id", 32'(rsp_id), 32'(id0));
            chk("hold_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        wait_rsp(t);
        chk("after_hold_grant", 32'(rsp_id), 32'((id0 + 1) % N));
        @(posedge clk); #1;
        req_valid = '0;

        // Reset in the middle of NORM drops the operation; pointer returns to 0.
        req_valid = 4'b1000;
        wait_accept(3, t);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rsp_id", 32'(rsp_id), 0);
        chk("midrst_rsp_data", 32'(rsp_data), 0);
        chk("midrst_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        a_arr[1]  = 16'h07FF; b_arr[1] = 16'h07FF;
        req_valid = 4'b1110;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(t);
        chk("post_rst_data", 32'(rsp_data), 32'h07FE);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
